// File: rtl/alu_mc_if.sv
// Request/response bundle between the EX-stage control and the multi-cycle ALU.
//
// Handshake: a request transfers on a rising clk edge where in_valid && in_ready;
// the requester holds A/B/pc_idx/ALUOp stable until that edge. A result transfers
// on a rising edge where out_valid && out_ready; C and zero stay stable until then.
// Neither valid waits on the matching ready; in_ready never depends on in_valid.
interface alu_mc_if #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [PC_W-1:0]  pc_idx;
    logic [4:0]       ALUOp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] C;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, A, B, pc_idx, ALUOp, out_ready,
        input  in_ready, out_valid, C, zero, busy
    );

    modport slave (
        input  in_valid, A, B, pc_idx, ALUOp, out_ready,
        output in_ready, out_valid, C, zero, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle ops complete at the accept edge,
// mul/mulhu/divu/remu iterate one bit per cycle (shift-add / restoring divide).
// Results are registered and held until the consumer takes them.
// dbg_state exposes the FSM state: 0 = IDLE, 1 = ITER, 2 = HOLD.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 6
) (
    input  logic       clk,
    input  logic       rstn,
    alu_mc_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W-1:0] LAST_STEP = SH_W'(WIDTH - 1);

    localparam logic [4:0] OP_LUI   = 5'b00001;
    localparam logic [4:0] OP_AUIPC = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_AND   = 5'b00101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_XOR   = 5'b00111;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SLT   = 5'b01001;
    localparam logic [4:0] OP_SLTU  = 5'b01010;
    localparam logic [4:0] OP_SRL   = 5'b01100;
    localparam logic [4:0] OP_SRA   = 5'b11000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, zero_d;
    // Iteration registers: hi = product high half / partial remainder,
    // lo = multiplier bits / quotient bits, m = multiplicand / divisor.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [SH_W-1:0]  count_q, count_d;
    // Low two opcode bits of the iterative op: bit1 = divide, bit0 = take hi.
    logic [1:0]       iop_q, iop_d;

    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;
    logic             accept;
    logic             is_iter;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sra_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] iter_res;

    assign shamt   = bus.B[SH_W-1:0];
    assign is_iter = (bus.ALUOp[4:2] == 3'b100);
    assign sra_res = $signed(bus.A) >>> shamt;

    // Single-cycle result for the op currently presented; unknown codes keep C.
    always_comb begin
        sc_res = c_q;
        case (bus.ALUOp)
            OP_LUI:   sc_res = bus.B;
            OP_AUIPC: sc_res = (WIDTH'(bus.pc_idx) << 2) + bus.B;
            OP_ADD:   sc_res = bus.A + bus.B;
            OP_SUB:   sc_res = bus.A - bus.B;
            OP_AND:   sc_res = bus.A & bus.B;
            OP_OR:    sc_res = bus.A | bus.B;
            OP_XOR:   sc_res = bus.A ^ bus.B;
            OP_SLL:   sc_res = bus.A << shamt;
            OP_SRL:   sc_res = bus.A >> shamt;
            OP_SRA:   sc_res = sra_res;
            OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            default:  sc_res = c_q;
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide.
    always_comb begin
        // Multiply: add m into the high half when the current multiplier bit is
        // set, then shift the whole {carry, hi, lo} right by one.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        // Divide: shift the next dividend bit into the remainder and subtract
        // the divisor when it fits. A zero divisor always "fits", which yields
        // an all-ones quotient and a remainder equal to A with no special case.
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_ge   = (div_sh >= {1'b0, m_q});
        if (iop_q[1]) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        iter_res = iop_q[0] ? step_hi : step_lo;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        zero_d      = zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        m_d         = m_q;
        count_d     = count_q;
        iop_d       = iop_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                accept     = bus.in_valid;
            end
            ITER: begin
                busy_c  = 1'b1;
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = count_q + SH_W'(1);
                // The final step's result goes straight into C.
                if (count_q == LAST_STEP) begin
                    c_d     = iter_res;
                    zero_d  = (iter_res == '0);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        accept = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operands are captured only here, so later input changes are ignored.
        if (accept) begin
            if (is_iter) begin
                hi_d    = '0;
                lo_d    = bus.A;
                m_d     = bus.B;
                iop_d   = bus.ALUOp[1:0];
                count_d = '0;
                state_d = ITER;
            end else begin
                c_d     = sc_res;
                zero_d  = (sc_res == '0);
                state_d = HOLD;
            end
        end
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            c_q     <= '0;
            zero_q  <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            count_q <= '0;
            iop_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            count_q <= count_d;
            iop_q   <= iop_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.C         = c_q;
    assign bus.zero      = zero_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit instance checked every cycle against a
// transaction-level model, plus a 16-bit instance with directed/random ops.
module tb_alu_mc;
    localparam int W   = 32;
    localparam int W16 = 16;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LUI   = 5'b00001;
    localparam logic [4:0] OP_AUIPC = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_SUB   = 5'b00100;
    localparam logic [4:0] OP_AND   = 5'b00101;
    localparam logic [4:0] OP_OR    = 5'b00110;
    localparam logic [4:0] OP_XOR   = 5'b00111;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SLT   = 5'b01001;
    localparam logic [4:0] OP_SLTU  = 5'b01010;
    localparam logic [4:0] OP_SRL   = 5'b01100;
    localparam logic [4:0] OP_SRA   = 5'b11000;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULHU = 5'b10001;
    localparam logic [4:0] OP_DIVU  = 5'b10010;
    localparam logic [4:0] OP_REMU  = 5'b10011;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] dbg32;
    logic [1:0] dbg16;
    int         n_checks = 0;
    int         n_fails  = 0;
    bit         chk_en   = 1'b0;

    // Transaction-level model of the 32-bit instance.
    logic [W-1:0] m_c      = '0;
    logic [W-1:0] m_pres   = '0;
    bit           m_valid  = 1'b0;
    bit           m_pend   = 1'b0;
    bit           m_ir     = 1'b0;
    longint       cyc      = 0;
    longint       m_ready_at = 0;
    logic [63:0]  m_res;

    alu_mc_if #(.WIDTH(W),   .PC_W(6)) b32 ();
    alu_mc_if #(.WIDTH(W16), .PC_W(6)) b16 ();

    alu_mc #(.WIDTH(W),   .PC_W(6)) dut32 (.clk(clk), .rstn(rstn), .bus(b32), .dbg_state(dbg32));
    alu_mc #(.WIDTH(W16), .PC_W(6)) dut16 (.clk(clk), .rstn(rstn), .bus(b16), .dbg_state(dbg16));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: end of test not reached by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference ----------------
    function automatic bit is_iter_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // Result of one op at width w from the arithmetic definitions.
    function automatic logic [63:0] ref_fn(input int w, input logic [4:0] op,
                                           input logic [63:0] a_in, input logic [63:0] b_in,
                                           input logic [63:0] pc, input logic [63:0] prev);
        logic [63:0] mask, a, b, sa, sb, r;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        a  = a_in & mask;
        b  = b_in & mask;
        sa = a[w-1] ? (a | ~mask) : a;
        sb = b[w-1] ? (b | ~mask) : b;
        sh = int'(b % 64'(w));
        case (op)
            OP_LUI:   r = b;
            OP_AUIPC: r = (pc << 2) + b;
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SLL:   r = a << sh;
            OP_SRL:   r = a >> sh;
            OP_SRA:   r = $signed(sa) >>> sh;
            OP_SLT:   r = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
            OP_SLTU:  r = (a < b) ? 64'd1 : 64'd0;
            OP_MUL:   r = a * b;
            OP_MULHU: r = (a * b) >> w;
            OP_DIVU:  r = (b == 64'd0) ? mask : (a / b);
            OP_REMU:  r = (b == 64'd0) ? a : (a % b);
            default:  r = prev;
        endcase
        return r & mask;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 15));
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            if (n_fails <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model advances on each accepted/retired transfer of the 32-bit instance.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_c     = '0;
            m_valid = 1'b0;
            m_pend  = 1'b0;
            cyc     = 0;
        end else begin
            cyc++;
            m_ir = !m_pend && (!m_valid || b32.out_ready);
            if (m_valid && b32.out_ready) m_valid = 1'b0;
            if (m_pend && cyc == m_ready_at) begin
                m_c     = m_pres;
                m_valid = 1'b1;
                m_pend  = 1'b0;
            end
            if (b32.in_valid && m_ir) begin
                m_res = ref_fn(W, b32.ALUOp, 64'(b32.A), 64'(b32.B), 64'(b32.pc_idx), 64'(m_c));
                if (is_iter_op(b32.ALUOp)) begin
                    m_pend     = 1'b1;
                    m_pres     = m_res[W-1:0];
                    m_ready_at = cyc + W;
                end else begin
                    m_c     = m_res[W-1:0];
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of the 32-bit instance against the model.
    always @(negedge clk) begin
        if (rstn && chk_en) begin
            check("cyc_out_valid", 64'(b32.out_valid), 64'(m_valid));
            check("cyc_in_ready",  64'(b32.in_ready),  64'(!m_pend && (!m_valid || b32.out_ready)));
            check("cyc_busy",      64'(b32.busy),      64'(m_pend));
            check("cyc_C",         64'(b32.C),         64'(m_c));
            check("cyc_zero",      64'(b32.zero),      64'(m_c == '0));
        end
    end

    // ---------------- drivers ----------------
    task automatic send32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] pc);
        bit ok, acc;
        @(posedge clk); #1;
        b32.ALUOp = op; b32.A = a; b32.B = b; b32.pc_idx = pc; b32.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk); acc = b32.in_ready;
            @(posedge clk); #1;
            if (acc) ok = 1'b1;
        end
        // Scramble the held inputs after accept: they must no longer matter.
        b32.in_valid = 1'b0;
        b32.A = $urandom; b32.B = $urandom; b32.pc_idx = 6'($urandom_range(0, 63));
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait32(output logic [31:0] c, output logic z, output int lat,
                          output int busy_n, output int ir_n);
        lat = 0; busy_n = 0; ir_n = 0; c = '0; z = 1'b0;
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            @(negedge clk);
            if (b32.busy) busy_n++;
            if (b32.out_valid) begin
                lat = n; c = b32.C; z = b32.zero;
            end else if (b32.in_ready) begin
                ir_n++;
            end
        end
    endtask

    task automatic dir32(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] pc, input logic [31:0] exp);
        logic [31:0] c; logic z; int lat, bn, irn;
        send32(op, a, b, pc);
        wait32(c, z, lat, bn, irn);
        check({name, "_C"}, 64'(c), 64'(exp));
        check({name, "_zero"}, 64'(z), 64'(exp == 32'h0));
        if (is_iter_op(op)) begin
            check({name, "_latency"}, 64'(lat), 64'(W + 1));
            check({name, "_busy_cycles"}, 64'(bn), 64'(W));
            check({name, "_in_ready_low"}, 64'(irn), 64'd0);
        end else begin
            check({name, "_latency"}, 64'(lat), 64'd1);
        end
    endtask

    task automatic run16(input string name, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
        int lat; logic [15:0] c;
        @(posedge clk); #1;
        b16.ALUOp = op; b16.A = a; b16.B = b; b16.pc_idx = 6'd0; b16.in_valid = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(b16.in_ready), 64'd1);
        @(posedge clk); #1;
        b16.in_valid = 1'b0; b16.A = 16'($urandom); b16.B = 16'($urandom);
        lat = 0; c = '0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (b16.out_valid) begin lat = n; c = b16.C; end
        end
        check({name, "_C"}, 64'(c), 64'(exp));
        check({name, "_latency"}, 64'(lat), is_iter_op(op) ? 64'(W16 + 1) : 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] c; logic z; int lat, bn, irn, stale;
        bit acc;
        logic [15:0] prev16, a16, b16v, e16;
        logic [4:0]  op16;
        logic [63:0] r64;

        b32.in_valid = 1'b0; b32.out_ready = 1'b1; b32.A = '0; b32.B = '0;
        b32.pc_idx = '0; b32.ALUOp = OP_NOP;
        b16.in_valid = 1'b0; b16.out_ready = 1'b1; b16.A = '0; b16.B = '0;
        b16.pc_idx = '0; b16.ALUOp = OP_NOP;

        // Hand-computed pins on the reference itself.
        check("model_add_wrap", ref_fn(32, OP_ADD, 64'hFFFF_FFFF, 64'd1, 0, 0), 64'h0);
        check("model_sra",      ref_fn(32, OP_SRA, 64'h8000_0000, 64'h24, 0, 0), 64'hF800_0000);
        check("model_mulhu",    ref_fn(32, OP_MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0), 64'hFFFF_FFFE);
        check("model_remu0",    ref_fn(32, OP_REMU, 64'd5, 64'd0, 0, 0), 64'd5);
        check("model_sra16",    ref_fn(16, OP_SRA, 64'h8000, 64'h24, 0, 0), 64'hF800);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("reset_C",        64'(b32.C), 64'h0);
        check("reset_zero",     64'(b32.zero), 64'd1);
        check("reset_out_valid",64'(b32.out_valid), 64'd0);
        check("reset_busy",     64'(b32.busy), 64'd0);
        check("reset_in_ready", 64'(b32.in_ready), 64'd1);
        check("reset_idle32",   64'(dbg32), 64'd0);
        check("reset_idle16",   64'(dbg16), 64'd0);
        check("reset_C16",      64'(b16.C), 64'h0);
        chk_en = 1'b1;

        // Directed cases with hand-computed results.
        dir32("add_wrap",  OP_ADD,   32'hFFFF_FFFF, 32'd1, 6'd0, 32'h0);
        dir32("sub",       OP_SUB,   32'd5, 32'd7, 6'd0, 32'hFFFF_FFFE);
        dir32("slt",       OP_SLT,   32'hFFFF_FFFF, 32'd1, 6'd0, 32'd1);
        dir32("sltu",      OP_SLTU,  32'hFFFF_FFFF, 32'd1, 6'd0, 32'd0);
        dir32("sra",       OP_SRA,   32'h8000_0000, 32'h24, 6'd0, 32'hF800_0000);
        dir32("srl",       OP_SRL,   32'h8000_0000, 32'h24, 6'd0, 32'h0800_0000);
        dir32("auipc",     OP_AUIPC, 32'd0, 32'h1000, 6'd3, 32'h100C);
        dir32("mul",       OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 32'h1);
        dir32("mulhu",     OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 32'hFFFF_FFFE);
        dir32("divu",      OP_DIVU,  32'd100, 32'd7, 6'd0, 32'd14);
        dir32("remu",      OP_REMU,  32'd100, 32'd7, 6'd0, 32'd2);
        dir32("divu_by0",  OP_DIVU,  32'd5, 32'd0, 6'd0, 32'hFFFF_FFFF);
        dir32("remu_by0",  OP_REMU,  32'd5, 32'd0, 6'd0, 32'd5);
        dir32("nop_keeps", OP_NOP,   32'h1234, 32'h5678, 6'd0, 32'd5);

        // Back-pressure: the held result must stay put.
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        send32(OP_ADD, 32'd1, 32'd2, 6'd0);
        wait32(c, z, lat, bn, irn);
        check("bp_latency", 64'(lat), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_C_stable",     64'(b32.C), 64'd3);
            check("bp_valid_stable", 64'(b32.out_valid), 64'd1);
            check("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
        end
        @(posedge clk); #1;
        b32.out_ready = 1'b1;
        b32.ALUOp = OP_XOR; b32.A = 32'hF0; b32.B = 32'hFF; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_xor_C",     64'(b32.C), 64'h0F);
        check("b2b_xor_valid", 64'(b32.out_valid), 64'd1);

        // Reset in the middle of a divide discards it.
        send32(OP_DIVU, 32'd100, 32'd7, 6'd0);
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", 64'(b32.out_valid), 64'd0);
        check("midrst_busy",      64'(b32.busy), 64'd0);
        check("midrst_C",         64'(b32.C), 64'h0);
        check("midrst_zero",      64'(b32.zero), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 64'(b32.in_ready), 64'd1);
        check("postrst_idle",     64'(dbg32), 64'd0);
        stale = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (b32.out_valid) stale++;
        end
        check("postrst_no_stale", 64'(stale), 64'd0);

        // Random traffic with random back-pressure; the model checks each cycle.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk); acc = b32.in_valid && b32.in_ready;
            @(posedge clk); #1;
            if (acc || !b32.in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    b32.ALUOp  = 5'($urandom_range(0, 31));
                    b32.A      = rnd32();
                    b32.B      = rnd32();
                    b32.pc_idx = 6'($urandom_range(0, 63));
                    b32.in_valid = 1'b1;
                end else begin
                    b32.in_valid = 1'b0;
                end
            end
            b32.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        repeat (40) @(posedge clk);

        // 16-bit instance: directed then random.
        run16("w16_mul",   OP_MUL,   16'hFFFF, 16'hFFFF, 16'h0001);
        run16("w16_mulhu", OP_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE);
        run16("w16_sra",   OP_SRA,   16'h8000, 16'h0024, 16'hF800);
        run16("w16_divu",  OP_DIVU,  16'd1000, 16'd7, 16'd142);
        prev16 = 16'hF800 ;
        prev16 = 16'd142;
        for (int i = 0; i < 24; i++) begin
            op16 = 5'($urandom_range(0, 31));
            a16  = 16'($urandom);
            b16v = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            r64  = ref_fn(W16, op16, 64'(a16), 64'(b16v), 64'd0, 64'(prev16));
            e16  = r64[15:0];
            run16("w16_rand", op16, a16, b16v, e16);
            prev16 = e16;
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
